// File: rtl/multicycle_alu.sv
// multicycle_alu: single-cycle logic/arithmetic ops plus iterative radix-2
// multiply and restoring divide, behind a valid/ready handshake. Results and
// flags are registered and held until the consumer takes them.
module multicycle_alu #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       alucontrol,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             zero,
  output logic             overflow,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_XOR  = 4'b0011;
  localparam logic [3:0] OP_NOR  = 4'b0100;
  localparam logic [3:0] OP_SLTU = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_DIV  = 4'b1010;

  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  // Registered state
  state_t           state_q,     state_d;
  logic             is_div_q,    is_div_d;
  logic             neg_lo_q,    neg_lo_d;    // negate product / quotient at the end
  logic             neg_hi_q,    neg_hi_d;    // negate remainder at the end
  logic             ovf_pend_q,  ovf_pend_d;  // DIV MIN / -1 seen at accept
  logic [WIDTH-1:0] mcand_q,     mcand_d;     // multiplicand or divisor magnitude
  logic [WIDTH-1:0] acc_hi_q,    acc_hi_d;    // partial product high / partial remainder
  logic [WIDTH-1:0] acc_lo_q,    acc_lo_d;    // multiplier bits / quotient bits
  logic [CW-1:0]    cnt_q,       cnt_d;
  logic [WIDTH-1:0] res_q,       res_d;
  logic [WIDTH-1:0] res_hi_q,    res_hi_d;
  logic             zero_q,      zero_d;
  logic             ovf_q,       ovf_d;
  logic             dbz_q,       dbz_d;
  logic             out_valid_q, out_valid_d;

  // Operand decode at accept time
  logic             accept;
  logic             is_muldiv;
  logic             is_signed_op;
  logic             div_zero_case;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH-1:0] add_sum, sub_diff;
  logic [WIDTH-1:0] sc_res;
  logic             sc_ovf;

  // Iteration datapath
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic               div_ok;
  logic [WIDTH-1:0]   div_rem_sub;
  logic [WIDTH-1:0]   iter_hi, iter_lo;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  assign in_ready  = (state_q == IDLE) | ((state_q == DONE) & out_ready);
  assign accept    = in_valid & in_ready;

  assign is_muldiv     = (alucontrol[3:2] == 2'b10);
  assign is_signed_op  = is_muldiv & ~alucontrol[0];
  assign div_zero_case = is_muldiv & alucontrol[1] & (SrcB == '0);
  assign a_neg         = is_signed_op & SrcA[WIDTH-1];
  assign b_neg         = is_signed_op & SrcB[WIDTH-1];
  assign a_mag         = a_neg ? -SrcA : SrcA;
  assign b_mag         = b_neg ? -SrcB : SrcB;

  assign add_sum  = SrcA + SrcB;
  assign sub_diff = SrcA - SrcB;

  // Shift-add step: conditionally add the multiplicand, then shift {hi,lo} right.
  assign mul_sum = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});

  // Restoring-divide step: shift in the next dividend bit and trial-subtract.
  assign div_shift   = {acc_hi_q, acc_lo_q[WIDTH-1]};
  assign div_ok      = (div_shift >= {1'b0, mcand_q});
  assign div_rem_sub = WIDTH'(div_shift - {1'b0, mcand_q});

  // Single-cycle result and signed-overflow flag from the live operands.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    sc_res = '0;
    sc_ovf = 1'b0;
    case (alucontrol)
      OP_AND:  sc_res = SrcA & SrcB;
      OP_OR:   sc_res = SrcA | SrcB;
      OP_ADD: begin
        sc_res = add_sum;
        sc_ovf = (SrcA[WIDTH-1] == SrcB[WIDTH-1]) && (add_sum[WIDTH-1] != SrcA[WIDTH-1]);
      end
      OP_XOR:  sc_res = SrcA ^ SrcB;
      OP_NOR:  sc_res = ~(SrcA | SrcB);
      OP_SLTU: sc_res[0] = (SrcA < SrcB);
      OP_SUB: begin
        sc_res = sub_diff;
        sc_ovf = (SrcA[WIDTH-1] != SrcB[WIDTH-1]) && (sub_diff[WIDTH-1] != SrcA[WIDTH-1]);
      end
      OP_SLT:  sc_res[0] = ($signed(SrcA) < $signed(SrcB));
      default: sc_res = '0;
    endcase
  end

  // Next accumulator values for one multiply or divide iteration.
  always_comb begin
    if (is_div_q) begin
      if (div_ok) begin
        iter_hi = div_rem_sub;
        iter_lo = {acc_lo_q[WIDTH-2:0], 1'b1};
      end else begin
        iter_hi = div_shift[WIDTH-1:0];
        iter_lo = {acc_lo_q[WIDTH-2:0], 1'b0};
      end
    end else begin
      {iter_hi, iter_lo} = {mul_sum, acc_lo_q[WIDTH-1:1]};
    end
  end

  // Sign restoration applied to the final iteration's values.
  assign prod_fix = neg_lo_q ? -{iter_hi, iter_lo} : {iter_hi, iter_lo};
  assign quo_fix  = neg_lo_q ? -iter_lo : iter_lo;
  assign rem_fix  = neg_hi_q ? -iter_hi : iter_hi;

  // FSM next-state, operand capture, iteration and result update.
  always_comb begin
    state_d     = state_q;
    is_div_d    = is_div_q;
    neg_lo_d    = neg_lo_q;
    neg_hi_d    = neg_hi_q;
    ovf_pend_d  = ovf_pend_q;
    mcand_d     = mcand_q;
    acc_hi_d    = acc_hi_q;
    acc_lo_d    = acc_lo_q;
    cnt_d       = cnt_q;
    res_d       = res_q;
    res_hi_d    = res_hi_q;
    ovf_d       = ovf_q;
    dbz_d       = dbz_q;
    out_valid_d = out_valid_q;

    case (state_q)
      BUSY: begin
        acc_hi_d = iter_hi;
        acc_lo_d = iter_lo;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) begin
          if (is_div_q) begin
            res_d    = quo_fix;
            res_hi_d = rem_fix;
            ovf_d    = ovf_pend_q;
          end else begin
            {res_hi_d, res_d} = prod_fix;
            ovf_d             = 1'b0;
          end
          dbz_d       = 1'b0;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end
      end
      default: begin
        if ((state_q == DONE) && out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
        if (accept) begin
          if (is_muldiv && !div_zero_case) begin
            is_div_d    = alucontrol[1];
            neg_lo_d    = a_neg ^ b_neg;
            neg_hi_d    = a_neg;
            ovf_pend_d  = (alucontrol == OP_DIV) && (SrcA == MIN_VAL) && (SrcB == '1);
            mcand_d     = b_mag;
            acc_hi_d    = '0;
            acc_lo_d    = a_mag;
            cnt_d       = '0;
            out_valid_d = 1'b0;
            state_d     = BUSY;
          end else if (div_zero_case) begin
            res_d       = '1;
            res_hi_d    = SrcA;
            ovf_d       = 1'b0;
            dbz_d       = 1'b1;
            out_valid_d = 1'b1;
            state_d     = DONE;
          end else begin
            res_d       = sc_res;
            res_hi_d    = '0;
            ovf_d       = sc_ovf;
            dbz_d       = 1'b0;
            out_valid_d = 1'b1;
            state_d     = DONE;
          end
        end
      end
    endcase

    // res_q and zero_q always change together, so zero tracks the held result.
    zero_d = (res_d == '0);
  end

  // State and output registers; reset aborts any operation in flight.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      is_div_q    <= 1'b0;
      neg_lo_q    <= 1'b0;
      neg_hi_q    <= 1'b0;
      ovf_pend_q  <= 1'b0;
      mcand_q     <= '0;
      acc_hi_q    <= '0;
      acc_lo_q    <= '0;
      cnt_q       <= '0;
      res_q       <= '0;
      res_hi_q    <= '0;
      zero_q      <= 1'b1;
      ovf_q       <= 1'b0;
      dbz_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      state_q     <= state_d;
      is_div_q    <= is_div_d;
      neg_lo_q    <= neg_lo_d;
      neg_hi_q    <= neg_hi_d;
      ovf_pend_q  <= ovf_pend_d;
      mcand_q     <= mcand_d;
      acc_hi_q    <= acc_hi_d;
      acc_lo_q    <= acc_lo_d;
      cnt_q       <= cnt_d;
      res_q       <= res_d;
      res_hi_q    <= res_hi_d;
      zero_q      <= zero_d;
      ovf_q       <= ovf_d;
      dbz_q       <= dbz_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign result      = res_q;
  assign result_hi   = res_hi_q;
  assign zero        = zero_q;
  assign overflow    = ovf_q;
  assign div_by_zero = dbz_q;
  assign out_valid   = out_valid_q;

endmodule
